// File: rtl/dfi_pkg.sv
// Shared constants and helpers for the DFI datapath timing controller.
// Reset latencies match the legacy fixed-CL PHY so existing init sequences still line up.
package dfi_pkg;

  localparam int NPHASES_DEF = 2;
  localparam int RDLAT_RST   = 3;
  localparam int WRLAT_RST   = 1;

  // Saturate a requested latency into 1..max_lat; zero is not a usable tap.
  function automatic int clamp_lat(input int req, input int max_lat);
    if (req < 1) return 1;
    if (req > max_lat) return max_lat;
    return req;
  endfunction

endpackage

// File: rtl/dfi_delay_line.sv
// Shift-register delay line with a runtime-selected output tap and every stage exposed.
// The asynchronous clear flushes in-flight strobes so nothing stale leaks out after reset.
module dfi_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  parameter int SEL_W = 4
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic [WIDTH-1:0]       din,
  input  logic [SEL_W-1:0]       sel,
  output logic [WIDTH-1:0]       dout,
  output logic [DEPTH*WIDTH-1:0] taps
);

  logic [WIDTH-1:0] pipe_p [DEPTH];

  // Stage 0 captures the input; stage i holds the value from i+1 edges ago.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) pipe_p[i] <= '0;
    end else begin
      pipe_p[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe_p[i] <= pipe_p[i-1];
    end
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel == SEL_W'(i)) dout = pipe_p[i];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_taps
    assign taps[g*WIDTH +: WIDTH] = pipe_p[g];
  end

endmodule

// File: rtl/dfi_datapath_timer.sv
// DFI datapath timer: delays per-phase read enables into rddata_valid and shapes write
// enables into DQ/DQS output enables with preamble/postamble, flagging bus turnaround clashes.
module dfi_datapath_timer import dfi_pkg::*; #(
  parameter int NPHASES   = NPHASES_DEF,
  parameter int LAT_W     = 4,
  parameter int MAX_RDLAT = 15,
  parameter int MAX_WRLAT = 7
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [LAT_W-1:0]   cfg_rdlat,
  input  logic [LAT_W-1:0]   cfg_wrlat,
  input  logic               err_clr,
  input  logic [NPHASES-1:0] dfi_rddata_en,
  input  logic [NPHASES-1:0] dfi_wrdata_en,
  output logic [NPHASES-1:0] dfi_rddata_valid,
  output logic               drive_dq,
  output logic               drive_dqs,
  output logic               dqs_postamble,
  output logic [LAT_W-1:0]   rdlat_active,
  output logic [LAT_W-1:0]   wrlat_active,
  output logic               busy,
  output logic               conflict
);

  // One extra write stage so the postamble tap exists at the deepest write latency.
  localparam int WR_DEPTH = MAX_WRLAT + 1;

  logic [LAT_W-1:0]           rd_clamped;
  logic [LAT_W-1:0]           wr_clamped;
  logic                       lat_load;
  logic [LAT_W-1:0]           rd_sel;
  logic [LAT_W-1:0]           wr_sel;
  logic [MAX_RDLAT*NPHASES-1:0] rd_taps;
  logic [WR_DEPTH-1:0]        wr_taps;
  logic                       wr_any;
  logic                       wr_pre;
  logic                       wr_post;
  logic                       conflict_set;

  assign rd_clamped = LAT_W'(clamp_lat(32'(cfg_rdlat), MAX_RDLAT));
  assign wr_clamped = LAT_W'(clamp_lat(32'(cfg_wrlat), MAX_WRLAT));

  // Latencies only move while both pipes are empty, so no strobe is ever re-timed mid-flight.
  assign lat_load = !busy && (dfi_rddata_en == '0) && (dfi_wrdata_en == '0);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rdlat_active <= LAT_W'(RDLAT_RST);
      wrlat_active <= LAT_W'(WRLAT_RST);
    end else if (lat_load) begin
      rdlat_active <= rd_clamped;
      wrlat_active <= wr_clamped;
    end
  end

  assign rd_sel = rdlat_active - LAT_W'(1);
  assign wr_sel = wrlat_active - LAT_W'(1);
  assign wr_any = |dfi_wrdata_en;

  // Read path: phase-preserving delay, tap at rdlat-1.
  dfi_delay_line #(
    .WIDTH (NPHASES),
    .DEPTH (MAX_RDLAT),
    .SEL_W (LAT_W)
  ) u_rd_line (
    .clk   (sys_clk),
    .clr_n (sys_rst_n),
    .din   (dfi_rddata_en),
    .sel   (rd_sel),
    .dout  (dfi_rddata_valid),
    .taps  (rd_taps)
  );

  // Write path: phases collapse to one burst bit; the main tap is the DQ enable.
  dfi_delay_line #(
    .WIDTH (1),
    .DEPTH (WR_DEPTH),
    .SEL_W (LAT_W)
  ) u_wr_line (
    .clk   (sys_clk),
    .clr_n (sys_rst_n),
    .din   (wr_any),
    .sel   (wr_sel),
    .dout  (drive_dq),
    .taps  (wr_taps)
  );

  // Preamble sits one stage ahead of the DQ tap, postamble one stage behind it.
  always_comb begin
    wr_pre  = 1'b0;
    wr_post = 1'b0;
    for (int i = 0; i < WR_DEPTH; i++) begin
      if (int'(wrlat_active) == i + 2) wr_pre  = wr_taps[i];
      if (int'(wrlat_active) == i)     wr_post = wr_taps[i];
    end
  end

  assign drive_dqs     = drive_dq | wr_pre;
  assign dqs_postamble = wr_post & ~drive_dq;
  assign busy          = (|rd_taps) | (|wr_taps);

  assign conflict_set = (drive_dqs | dqs_postamble) & (|dfi_rddata_valid);

  // Sticky error; a coincident set beats the clear.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) conflict <= 1'b0;
    else            conflict <= conflict_set | (conflict & ~err_clr);
  end

endmodule

// File: tb/tb_dfi_datapath_timer.sv
// Directed bench for dfi_datapath_timer: a history-based timing model checked every cycle,
// plus hand-computed literal expectations at key cycles.
module tb_dfi_datapath_timer;

  localparam int NP = 2;
  localparam int LW = 4;
  localparam int MAXRD = 15;
  localparam int MAXWR = 7;
  localparam int HD = 24;
  localparam int NLOG = 256;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic [LW-1:0] cfg_rdlat, cfg_wrlat;
  logic          err_clr;
  logic [NP-1:0] dfi_rddata_en, dfi_wrdata_en;
  logic [NP-1:0] dfi_rddata_valid;
  logic          drive_dq, drive_dqs, dqs_postamble, busy, conflict;
  logic [LW-1:0] rdlat_active, wrlat_active;

  dfi_datapath_timer #(
    .NPHASES(NP), .LAT_W(LW), .MAX_RDLAT(MAXRD), .MAX_WRLAT(MAXWR)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cfg_rdlat(cfg_rdlat), .cfg_wrlat(cfg_wrlat), .err_clr(err_clr),
    .dfi_rddata_en(dfi_rddata_en), .dfi_wrdata_en(dfi_wrdata_en),
    .dfi_rddata_valid(dfi_rddata_valid), .drive_dq(drive_dq), .drive_dqs(drive_dqs),
    .dqs_postamble(dqs_postamble), .rdlat_active(rdlat_active), .wrlat_active(wrlat_active),
    .busy(busy), .conflict(conflict)
  );

  always #5 sys_clk = ~sys_clk;

  int nvec = 0;
  int nmis = 0;
  int cyc = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int bclamp(input int v, input int mx);
    return (v < 1) ? 1 : ((v > mx) ? mx : v);
  endfunction

  // Model: input history per past cycle (index k = k cycles ago) plus architectural state.
  logic [NP-1:0] h_rd [HD];
  logic          h_wr [HD];
  int            m_rdlat = 3, m_wrlat = 1;
  logic          m_conf = 1'b0;
  logic [NP-1:0] e_valid;
  logic          e_dq, e_dqs, e_post, e_busy;

  logic [NP-1:0] lg_valid [NLOG];
  logic          lg_dq [NLOG], lg_dqs [NLOG], lg_post [NLOG], lg_conf [NLOG];
  logic [LW-1:0] lg_rdlat [NLOG], lg_wrlat [NLOG];

  initial for (int k = 0; k < HD; k++) begin h_rd[k] = '0; h_wr[k] = 1'b0; end

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int k = 0; k < HD; k++) begin h_rd[k] = '0; h_wr[k] = 1'b0; end
      m_rdlat = 3; m_wrlat = 1; m_conf = 1'b0;
    end
    e_valid = h_rd[m_rdlat];
    e_dq    = h_wr[m_wrlat];
    e_dqs   = e_dq | ((m_wrlat >= 2) ? h_wr[m_wrlat-1] : 1'b0);
    e_post  = h_wr[m_wrlat+1] & ~e_dq;
    e_busy  = 1'b0;
    for (int k = 1; k <= MAXRD; k++) e_busy |= |h_rd[k];
    for (int k = 1; k <= MAXWR + 1; k++) e_busy |= h_wr[k];

    chk($sformatf("valid@%0d", cyc), 32'(dfi_rddata_valid), 32'(e_valid));
    chk($sformatf("dq@%0d", cyc), 32'(drive_dq), 32'(e_dq));
    chk($sformatf("dqs@%0d", cyc), 32'(drive_dqs), 32'(e_dqs));
    chk($sformatf("post@%0d", cyc), 32'(dqs_postamble), 32'(e_post));
    chk($sformatf("busy@%0d", cyc), 32'(busy), 32'(e_busy));
    chk($sformatf("conflict@%0d", cyc), 32'(conflict), 32'(m_conf));
    chk($sformatf("rdlat@%0d", cyc), 32'(rdlat_active), 32'(m_rdlat));
    chk($sformatf("wrlat@%0d", cyc), 32'(wrlat_active), 32'(m_wrlat));

    if (cyc < NLOG) begin
      lg_valid[cyc] = dfi_rddata_valid; lg_dq[cyc] = drive_dq; lg_dqs[cyc] = drive_dqs;
      lg_post[cyc] = dqs_postamble; lg_conf[cyc] = conflict;
      lg_rdlat[cyc] = rdlat_active; lg_wrlat[cyc] = wrlat_active;
    end

    if (sys_rst_n) begin
      m_conf = (((e_dqs | e_post) & (|e_valid)) | (m_conf & ~err_clr));
      if (!e_busy && dfi_rddata_en == '0 && dfi_wrdata_en == '0) begin
        m_rdlat = bclamp(int'(cfg_rdlat), MAXRD);
        m_wrlat = bclamp(int'(cfg_wrlat), MAXWR);
      end
      for (int k = HD - 1; k >= 2; k--) begin h_rd[k] = h_rd[k-1]; h_wr[k] = h_wr[k-1]; end
      h_rd[1] = dfi_rddata_en;
      h_wr[1] = |dfi_wrdata_en;
    end
  end

  task automatic go(input int k);
    while (cyc < k) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic rd_at(input int k, input logic [NP-1:0] v);
    go(k); dfi_rddata_en = v; go(k + 1); dfi_rddata_en = '0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 50000");
    $fatal(1);
  end

  initial begin
    sys_rst_n = 1'b0;
    cfg_rdlat = 4'd3; cfg_wrlat = 4'd2; err_clr = 1'b0;
    dfi_rddata_en = '0; dfi_wrdata_en = '0;
    go(2); sys_rst_n = 1'b1;

    rd_at(10, 2'b01);
    rd_at(16, 2'b10);
    go(20); dfi_wrdata_en = 2'b10; go(22); dfi_wrdata_en = '0;
    go(30); dfi_wrdata_en = 2'b01; go(31); dfi_wrdata_en = '0;
    go(32); dfi_wrdata_en = 2'b01; go(33); dfi_wrdata_en = '0;

    rd_at(50, 2'b01);
    cfg_rdlat = 4'd5;
    rd_at(70, 2'b01);

    go(90); cfg_rdlat = 4'd0; cfg_wrlat = 4'd15;
    rd_at(93, 2'b11);
    go(95); dfi_wrdata_en = 2'b11; go(96); dfi_wrdata_en = '0;

    go(110); cfg_rdlat = 4'd4; cfg_wrlat = 4'd2;
    rd_at(120, 2'b01);
    go(122); dfi_wrdata_en = 2'b01; go(123); dfi_wrdata_en = '0;
    go(128); err_clr = 1'b1; go(129); err_clr = 1'b0;
    rd_at(140, 2'b10);
    go(142); dfi_wrdata_en = 2'b10; go(143); dfi_wrdata_en = '0;
    go(144); err_clr = 1'b1; go(145); err_clr = 1'b0;
    go(150); err_clr = 1'b1; go(151); err_clr = 1'b0;

    go(160); dfi_rddata_en = 2'b01; dfi_wrdata_en = 2'b01;
    go(161); dfi_rddata_en = '0;
    go(163); dfi_wrdata_en = '0;
    #2 sys_rst_n = 1'b0;
    go(166); sys_rst_n = 1'b1;

    go(190);

    chk("lit_valid12", 32'(lg_valid[12]), 32'h0);
    chk("lit_valid13", 32'(lg_valid[13]), 32'h1);
    chk("lit_valid14", 32'(lg_valid[14]), 32'h0);
    chk("lit_valid19", 32'(lg_valid[19]), 32'h2);
    chk("lit_dqs20", 32'(lg_dqs[20]), 32'h0);
    chk("lit_dqs21", 32'(lg_dqs[21]), 32'h1);
    chk("lit_dq21", 32'(lg_dq[21]), 32'h0);
    chk("lit_dq22", 32'(lg_dq[22]), 32'h1);
    chk("lit_dq23", 32'(lg_dq[23]), 32'h1);
    chk("lit_dqs23", 32'(lg_dqs[23]), 32'h1);
    chk("lit_dq24", 32'(lg_dq[24]), 32'h0);
    chk("lit_dqs24", 32'(lg_dqs[24]), 32'h0);
    chk("lit_post23", 32'(lg_post[23]), 32'h0);
    chk("lit_post24", 32'(lg_post[24]), 32'h1);
    chk("lit_post25", 32'(lg_post[25]), 32'h0);
    chk("lit_dqs33", 32'(lg_dqs[33]), 32'h1);
    chk("lit_post33", 32'(lg_post[33]), 32'h1);
    chk("lit_valid53", 32'(lg_valid[53]), 32'h1);
    chk("lit_rdlat60", 32'(lg_rdlat[60]), 32'd3);
    chk("lit_rdlat66", 32'(lg_rdlat[66]), 32'd3);
    chk("lit_rdlat67", 32'(lg_rdlat[67]), 32'd5);
    chk("lit_valid75", 32'(lg_valid[75]), 32'h1);
    chk("lit_rdlat91", 32'(lg_rdlat[91]), 32'd1);
    chk("lit_wrlat91", 32'(lg_wrlat[91]), 32'd7);
    chk("lit_valid94", 32'(lg_valid[94]), 32'h3);
    chk("lit_dqs101", 32'(lg_dqs[101]), 32'h1);
    chk("lit_dq101", 32'(lg_dq[101]), 32'h0);
    chk("lit_dq102", 32'(lg_dq[102]), 32'h1);
    chk("lit_post103", 32'(lg_post[103]), 32'h1);
    chk("lit_conf124", 32'(lg_conf[124]), 32'h0);
    chk("lit_conf125", 32'(lg_conf[125]), 32'h1);
    chk("lit_conf128", 32'(lg_conf[128]), 32'h1);
    chk("lit_conf129", 32'(lg_conf[129]), 32'h0);
    chk("lit_conf145", 32'(lg_conf[145]), 32'h1);
    chk("lit_conf150", 32'(lg_conf[150]), 32'h1);
    chk("lit_conf151", 32'(lg_conf[151]), 32'h0);
    chk("lit_dq163", 32'(lg_dq[163]), 32'h0);
    chk("lit_valid164", 32'(lg_valid[164]), 32'h0);
    chk("lit_rdlat164", 32'(lg_rdlat[164]), 32'd3);
    chk("lit_wrlat164", 32'(lg_wrlat[164]), 32'd1);
    chk("lit_rdlat166", 32'(lg_rdlat[166]), 32'd3);
    chk("lit_rdlat167", 32'(lg_rdlat[167]), 32'd4);
    for (int c = 166; c < 186; c++)
      chk($sformatf("lit_novalid%0d", c), 32'(lg_valid[c]), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
